// File: rtl/edge_cov_accum_pkg.sv
// Shared types and size helpers for the edge coverage accumulator.
// Derived widths are computed here so the interface and the RTL always agree.
package edge_cov_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  function automatic int calc_n(input int num_ch, input int ch_w);
    return num_ch * ch_w;
  endfunction

  function automatic int calc_words(input int n, input int rd_w);
    return n / rd_w;
  endfunction

  // A single-word configuration still needs a one-bit address.
  function automatic int calc_aw(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int calc_cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/edge_cov_accum_if.sv
// Mask, readback and count signals between the mask producers / register slave
// (master side) and the coverage accumulator (slave side).
interface edge_cov_accum_if import edge_cov_pkg::*; #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = 512,
  parameter int RD_W   = 32
) ();
  localparam int N     = calc_n(NUM_CH, CH_W);
  localparam int WORDS = calc_words(N, RD_W);
  localparam int AW    = calc_aw(WORDS);
  localparam int CW    = calc_cw(N);

  logic [N-1:0]    mask_in;
  logic            mask_valid;
  logic            mask_ready;
  logic            clr_req;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic            rd_valid;
  logic [RD_W-1:0] rd_data;
  logic            cnt_req;
  logic            cnt_busy;
  logic            cnt_valid;
  logic [CW-1:0]   cov_count;
  logic            new_hit;

  modport master (
    output mask_in, mask_valid, clr_req, rd_req, rd_addr, cnt_req,
    input  mask_ready, rd_valid, rd_data, cnt_busy, cnt_valid, cov_count, new_hit
  );

  modport slave (
    input  mask_in, mask_valid, clr_req, rd_req, rd_addr, cnt_req,
    output mask_ready, rd_valid, rd_data, cnt_busy, cnt_valid, cov_count, new_hit
  );
endinterface

// File: rtl/edge_cov_accum_popcount.sv
// Combinational population count of one readback word.
module cov_popcount #(
  parameter  int RD_W = 32,
  localparam int PW   = $clog2(RD_W + 1)
) (
  input  logic [RD_W-1:0] din,
  output logic [PW-1:0]   cnt
);

  // Ripple sum of the word's bits.
  always_comb begin
    cnt = {PW{1'b0}};
    for (int i = 0; i < RD_W; i++) begin
      cnt = cnt + PW'(din[i]);
    end
  end

endmodule

// File: rtl/edge_cov_accum.sv
// Sticky coverage accumulator with word readback, new-coverage flag and a
// word-serial population count; clr_req overrides everything.
module edge_cov_accum import edge_cov_pkg::*; #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = 512,
  parameter int RD_W   = 32
) (
  input logic             CLK,
  input logic             RST_n,
  edge_cov_accum_if.slave bus
);
  localparam int N     = calc_n(NUM_CH, CH_W);
  localparam int WORDS = calc_words(N, RD_W);
  localparam int AW    = calc_aw(WORDS);
  localparam int CW    = calc_cw(N);
  localparam int PW    = $clog2(RD_W + 1);

  state_e          state_r;
  state_e          state_nxt_s;
  logic [N-1:0]    acc_r;
  logic [AW-1:0]   idx_r;
  logic [CW-1:0]   sum_r;
  logic [CW-1:0]   cov_count_r;
  logic            cnt_valid_r;
  logic            new_hit_r;
  logic            rd_valid_r;
  logic [RD_W-1:0] rd_data_r;
  logic [RD_W-1:0] cnt_word_s;
  logic [PW-1:0]   word_pop_s;
  logic            accept_s;
  logic            last_word_s;
  logic            mask_ready_s;
  logic            cnt_busy_s;

  assign accept_s    = bus.mask_valid & mask_ready_s & ~bus.clr_req;
  assign cnt_word_s  = acc_r[idx_r*RD_W +: RD_W];
  assign last_word_s = (idx_r == AW'(WORDS - 1));

  cov_popcount #(.RD_W(RD_W)) u_popcount (
    .din (cnt_word_s),
    .cnt (word_pop_s)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next state; clear always lands in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.clr_req) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (bus.cnt_req) state_nxt_s = COUNT; else state_nxt_s = IDLE;
        COUNT:   if (last_word_s) state_nxt_s = IDLE;  else state_nxt_s = COUNT;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM output decode.
  always_comb begin
    mask_ready_s = 1'b0;
    cnt_busy_s   = 1'b0;
    case (state_r)
      IDLE:    mask_ready_s = 1'b1;
      COUNT:   cnt_busy_s   = 1'b1;
      default: begin
        mask_ready_s = 1'b0;
        cnt_busy_s   = 1'b0;
      end
    endcase
  end

  // Coverage vector and new-coverage flag, judged against the pre-update vector.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      acc_r     <= {N{1'b0}};
      new_hit_r <= 1'b0;
    end else if (bus.clr_req) begin
      acc_r     <= {N{1'b0}};
      new_hit_r <= 1'b0;
    end else if (accept_s) begin
      acc_r     <= acc_r | bus.mask_in;
      new_hit_r <= |(bus.mask_in & ~acc_r);
    end else begin
      new_hit_r <= 1'b0;
    end
  end

  // Word readback; ignores clear so a colliding read sees pre-clear data.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= {RD_W{1'b0}};
    end else if (bus.rd_req) begin
      rd_valid_r <= 1'b1;
      if ({1'b0, bus.rd_addr} < (AW+1)'(WORDS)) rd_data_r <= acc_r[bus.rd_addr*RD_W +: RD_W];
      else                                      rd_data_r <= {RD_W{1'b0}};
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  // Count datapath: one word per COUNT cycle, result published after the last.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      idx_r       <= {AW{1'b0}};
      sum_r       <= {CW{1'b0}};
      cov_count_r <= {CW{1'b0}};
      cnt_valid_r <= 1'b0;
    end else begin
      cnt_valid_r <= 1'b0;
      if (bus.clr_req) begin
        idx_r       <= {AW{1'b0}};
        sum_r       <= {CW{1'b0}};
        cov_count_r <= {CW{1'b0}};
      end else if (state_r == IDLE) begin
        idx_r <= {AW{1'b0}};
        sum_r <= {CW{1'b0}};
      end else begin
        idx_r <= idx_r + AW'(1);
        sum_r <= sum_r + CW'(word_pop_s);
        if (last_word_s) begin
          cov_count_r <= sum_r + CW'(word_pop_s);
          cnt_valid_r <= 1'b1;
        end
      end
    end
  end

  assign bus.mask_ready = mask_ready_s;
  assign bus.cnt_busy   = cnt_busy_s;
  assign bus.new_hit    = new_hit_r;
  assign bus.rd_valid   = rd_valid_r;
  assign bus.rd_data    = rd_data_r;
  assign bus.cnt_valid  = cnt_valid_r;
  assign bus.cov_count  = cov_count_r;

endmodule

// File: tb/tb_edge_cov_accum.sv
// Scoreboard bench for edge_cov_accum: reads and counts queue their expected
// results when issued; a negedge monitor pops and compares them.
module tb_edge_cov_accum;
  localparam int N     = 4096;
  localparam int RD_W  = 32;
  localparam int WORDS = 128;
  localparam int CW    = 13;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  logic [N-1:0]    model_acc;
  logic [RD_W-1:0] rd_q[$];
  logic [CW-1:0]   cnt_q[$];
  logic [RD_W-1:0] exp_rd;
  logic [CW-1:0]   exp_cnt;

  edge_cov_accum_if #(.NUM_CH(8), .CH_W(512), .RD_W(RD_W)) bus ();

  edge_cov_accum #(.NUM_CH(8), .CH_W(512), .RD_W(RD_W)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  // Output monitor: every read strobe and count pulse must match the queue head.
  always @(negedge CLK) begin
    if (bus.rd_valid === 1'b1) begin
      tests_run++;
      if (rd_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rd_unexpected: rd_valid with no read pending, rd_data=%h", bus.rd_data);
      end else begin
        exp_rd = rd_q.pop_front();
        if (bus.rd_data !== exp_rd) begin
          tests_failed++;
          $display("FAIL rd_data: got %h expected %h", bus.rd_data, exp_rd);
        end
      end
    end
    if (bus.cnt_valid === 1'b1) begin
      tests_run++;
      if (cnt_q.size() == 0) begin
        tests_failed++;
        $display("FAIL cnt_unexpected: cnt_valid with no count pending, cov_count=%0d", bus.cov_count);
      end else begin
        exp_cnt = cnt_q.pop_front();
        if (bus.cov_count !== exp_cnt) begin
          tests_failed++;
          $display("FAIL cov_count: got %0d expected %0d", bus.cov_count, exp_cnt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mask_in    = '0;
    bus.mask_valid = 1'b0;
    bus.clr_req    = 1'b0;
    bus.rd_req     = 1'b0;
    bus.rd_addr    = 7'd0;
    bus.cnt_req    = 1'b0;
  endtask

  task automatic send_read(input int addr);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 7'(addr);
    rd_q.push_back(model_acc[addr*RD_W +: RD_W]);
    tick();
    bus.rd_req = 1'b0;
  endtask

  task automatic send_beat(input logic [N-1:0] m);
    bus.mask_in    = m;
    bus.mask_valid = 1'b1;
    model_acc      = model_acc | m;
    tick();
    bus.mask_valid = 1'b0;
  endtask

  task automatic send_clear();
    bus.clr_req = 1'b1;
    model_acc   = '0;
    tick();
    bus.clr_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    model_acc = '0;
    RST_n = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0) begin
      tests_failed++; $display("FAIL reset_rd: rd_valid=%b rd_data=%h expected 0/0", bus.rd_valid, bus.rd_data);
    end
    tests_run++;
    if (bus.new_hit !== 1'b0 || bus.cnt_valid !== 1'b0 || bus.cov_count !== 13'd0) begin
      tests_failed++; $display("FAIL reset_cnt: new_hit=%b cnt_valid=%b cov_count=%0d expected 0/0/0", bus.new_hit, bus.cnt_valid, bus.cov_count);
    end
    RST_n = 1'b1;
    tick();
    tests_run++;
    if (bus.mask_ready !== 1'b1 || bus.cnt_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_state: mask_ready=%b cnt_busy=%b expected 1/0", bus.mask_ready, bus.cnt_busy);
    end
  endtask

  task automatic test_empty_count();
    int k;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 7'd0;
    rd_q.push_back(32'h0000_0000);
    bus.cnt_req = 1'b1;
    cnt_q.push_back(13'd0);
    tick();
    bus.rd_req  = 1'b0;
    bus.cnt_req = 1'b0;
    k = 1;
    while (bus.cnt_valid !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    tests_run++;
    if (k != WORDS + 1) begin
      tests_failed++; $display("FAIL empty_count_latency: cnt_valid after %0d cycles expected %0d", k, WORDS + 1);
    end
    tick();
  endtask

  task automatic test_edges();
    logic [N-1:0] m;
    m = '0;
    m[0] = 1'b1;
    m[N-1] = 1'b1;
    send_beat(m);
    tests_run++;
    if (bus.new_hit !== 1'b1) begin
      tests_failed++; $display("FAIL edges_new_hit: got %b expected 1", bus.new_hit);
    end
    send_read(0);
    tests_run++;
    if (bus.new_hit !== 1'b0) begin
      tests_failed++; $display("FAIL edges_new_hit_idle: got %b expected 0", bus.new_hit);
    end
    send_read(WORDS - 1);
    send_beat(m);
    tests_run++;
    if (bus.new_hit !== 1'b0) begin
      tests_failed++; $display("FAIL edges_repeat_hit: got %b expected 0", bus.new_hit);
    end
    tick();
  endtask

  task automatic test_count_window();
    logic [N-1:0] m;
    int busy_bad;
    send_clear();
    m = '0;
    m[31:0] = 32'hFFFF_FFFF;
    m[100] = 1'b1;
    send_beat(m);
    bus.cnt_req = 1'b1;
    cnt_q.push_back(CW'($countones(model_acc)));
    tick();
    bus.cnt_req = 1'b0;
    busy_bad = 0;
    for (int k = 1; k <= WORDS; k++) begin
      if (bus.cnt_busy !== 1'b1 || bus.cnt_valid !== 1'b0 || bus.mask_ready !== 1'b0) busy_bad++;
      tick();
    end
    tests_run++;
    if (busy_bad != 0) begin
      tests_failed++; $display("FAIL count_busy_window: %0d bad cycles expected 0", busy_bad);
    end
    tests_run++;
    if (bus.cnt_valid !== 1'b1 || bus.cnt_busy !== 1'b0) begin
      tests_failed++; $display("FAIL count_done: cnt_valid=%b cnt_busy=%b expected 1/0", bus.cnt_valid, bus.cnt_busy);
    end
    tick();
  endtask

  task automatic test_hold_off();
    logic [N-1:0] m;
    int k;
    send_clear();
    m = '0;
    m[100] = 1'b1;
    send_beat(m);
    bus.cnt_req = 1'b1;
    cnt_q.push_back(CW'($countones(model_acc)));
    tick();
    bus.cnt_req = 1'b0;
    m = '0;
    m[5] = 1'b1;
    bus.mask_in = m;
    bus.mask_valid = 1'b1;
    tick();
    tests_run++;
    if (bus.mask_ready !== 1'b0 || bus.new_hit !== 1'b0) begin
      tests_failed++; $display("FAIL hold_off: mask_ready=%b new_hit=%b expected 0/0", bus.mask_ready, bus.new_hit);
    end
    repeat (3) tick();
    bus.mask_valid = 1'b0;
    k = 0;
    while (bus.cnt_valid !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    tests_run++;
    if (k >= 200) begin
      tests_failed++; $display("FAIL hold_off_timeout: no cnt_valid within %0d cycles", k);
    end
    tick();
    send_read(0);
    tick();
  endtask

  task automatic test_clear_abort();
    logic [N-1:0] m;
    int stray;
    m = '0;
    m[31:0] = 32'h0F0F_00FF;
    send_beat(m);
    bus.cnt_req = 1'b1;
    tick();
    bus.cnt_req = 1'b0;
    repeat (49) tick();
    send_clear();
    tests_run++;
    if (bus.cnt_busy !== 1'b0 || bus.cov_count !== 13'd0 || bus.mask_ready !== 1'b1) begin
      tests_failed++; $display("FAIL clear_abort: cnt_busy=%b cov_count=%0d mask_ready=%b expected 0/0/1", bus.cnt_busy, bus.cov_count, bus.mask_ready);
    end
    stray = 0;
    for (int k = 0; k < 150; k++) begin
      if (bus.cnt_valid !== 1'b0) stray++;
      tick();
    end
    tests_run++;
    if (stray != 0) begin
      tests_failed++; $display("FAIL clear_abort_pulse: %0d cnt_valid cycles expected 0", stray);
    end
    send_read(0);
    tick();
  endtask

  task automatic test_clear_collide();
    logic [N-1:0] m;
    m = '0;
    m[0] = 1'b1;
    send_beat(m);
    m = '0;
    m[7] = 1'b1;
    bus.mask_in    = m;
    bus.mask_valid = 1'b1;
    bus.clr_req    = 1'b1;
    bus.rd_req     = 1'b1;
    bus.rd_addr    = 7'd0;
    rd_q.push_back(32'h0000_0001);
    tick();
    idle_inputs();
    model_acc = '0;
    tests_run++;
    if (bus.new_hit !== 1'b0) begin
      tests_failed++; $display("FAIL collide_new_hit: got %b expected 0", bus.new_hit);
    end
    send_read(0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] m;
    logic exp_hit;
    int k;
    for (int j = 0; j < 8; j++) begin
      m = '0;
      m[((j / 2) * 523 + 17) % N] = 1'b1;
      bus.mask_in    = m;
      bus.mask_valid = 1'b1;
      exp_hit   = |(m & ~model_acc);
      model_acc = model_acc | m;
      tick();
      tests_run++;
      if (bus.new_hit !== exp_hit) begin
        tests_failed++; $display("FAIL b2b_new_hit[%0d]: got %b expected %b", j, bus.new_hit, exp_hit);
      end
    end
    bus.mask_valid = 1'b0;
    for (int a = 0; a < WORDS; a += 9) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 7'(a);
      rd_q.push_back(model_acc[a*RD_W +: RD_W]);
      tick();
    end
    bus.rd_req  = 1'b0;
    bus.cnt_req = 1'b1;
    cnt_q.push_back(CW'($countones(model_acc)));
    tick();
    bus.cnt_req = 1'b0;
    k = 1;
    while (bus.cnt_valid !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    tests_run++;
    if (k != WORDS + 1) begin
      tests_failed++; $display("FAIL b2b_count_latency: cnt_valid after %0d cycles expected %0d", k, WORDS + 1);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_empty_count();
    test_edges();
    test_count_window();
    test_hold_off();
    test_clear_abort();
    test_clear_collide();
    test_back_to_back();
    repeat (3) tick();
    tests_run++;
    if (rd_q.size() != 0 || cnt_q.size() != 0) begin
      tests_failed++; $display("FAIL drain: %0d reads and %0d counts outstanding expected 0/0", rd_q.size(), cnt_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
